config_tile_target: RTL and testbench

CONFIG_TILE_TARGET -- requirements
Module: config_tile_target

---
 rtl/config_tile_target.sv | 106 ++++++++++
 tb/tb_config_tile_target.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/config_tile_target.sv
// Tile-addressed configuration register bank with optional readback path.
// Define CONFIG_TILE_READBACK_EN to enable read strobes and read_valid_out.
module config_tile_target #(
   parameter logic [15:0] TILE_ID  = 16'h0015,
   parameter int          NUM_REGS = 8
) (
   input  logic                   clk_in,
   input  logic                   reset_in,
   input  logic [31:0]            config_addr_in,
   input  logic [31:0]            config_data_in,
   input  logic                   config_write_in,
   input  logic                   config_read_in,
   output logic [31:0]            read_data_out,
   output logic                   read_valid_out,
   output logic [NUM_REGS*32-1:0] cfg_regs_out,
   output logic                   config_err_out,
   output logic [15:0]            write_count_out
);

   logic [31:0] r_regs [NUM_REGS];
   logic [15:0] r_wcnt;
   logic        r_err;

   logic        w_hit;
   logic [7:0]  w_idx;
   logic        w_inrange;
   logic        w_wr;
   logic        w_rd;
   logic        w_err;

   assign w_hit     = (config_addr_in[15:0] == TILE_ID) &&
                      (config_addr_in[23:16] == 8'h00);
   assign w_idx     = config_addr_in[31:24];
   assign w_inrange = (w_idx < 8'(NUM_REGS));
   assign w_wr      = w_hit && config_write_in && w_inrange;

`ifdef CONFIG_TILE_READBACK_EN
   logic [31:0] r_rdata;
   logic        r_rvalid;
   logic [31:0] w_rsel;

   assign w_rd  = w_hit && config_read_in && !config_write_in && w_inrange;
   assign w_err = w_hit && ((!w_inrange && (config_write_in || config_read_in)) ||
                            (config_write_in && config_read_in));

   // Data captured at the strobe edge so a following write cannot leak in
   always_comb begin
      w_rsel = 32'h0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (w_idx == 8'(k)) w_rsel = r_regs[k];
      end
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         r_rdata  <= 32'h0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= w_rd;
         r_rdata  <= w_rd ? w_rsel : 32'h0;
      end
   end

   assign read_data_out  = r_rdata;
   assign read_valid_out = r_rvalid;
`else
   logic w_unused;

   assign w_unused       = config_read_in;
   assign w_rd           = 1'b0;
   assign w_err          = w_hit && config_write_in && !w_inrange;
   assign read_data_out  = 32'h0;
   assign read_valid_out = w_rd;
`endif

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= 32'h0;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (w_wr && (w_idx == 8'(k))) r_regs[k] <= config_data_in;
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         r_wcnt <= 16'h0;
         r_err  <= 1'b0;
      end else begin
         if (w_wr && (r_wcnt != 16'hFFFF)) r_wcnt <= r_wcnt + 16'h1;
         if (w_err) r_err <= 1'b1;
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_REGS; g++) begin : g_out
         assign cfg_regs_out[g*32 +: 32] = r_regs[g];
      end
   endgenerate

   assign config_err_out  = r_err;
   assign write_count_out = r_wcnt;

endmodule

// File: tb/tb_config_tile_target.sv
// Directed self-checking bench for config_tile_target (NUM_REGS=8).
// Read-path expectations follow CONFIG_TILE_READBACK_EN.
module tb_config_tile_target;

`ifdef CONFIG_TILE_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [31:0]  addr = '0;
   logic [31:0]  data = '0;
   logic         wr = 1'b0;
   logic         rd = 1'b0;
   logic [31:0]  rdata;
   logic         rvalid;
   logic [255:0] regs;
   logic         err;
   logic [15:0]  wcnt;

   logic [255:0] exp_regs = '0;
   int           npass = 0;
   int           ntot = 0;

   always #5 clk = ~clk;

   config_tile_target dut (
      .clk_in          (clk),
      .reset_in        (rst_n),
      .config_addr_in  (addr),
      .config_data_in  (data),
      .config_write_in (wr),
      .config_read_in  (rd),
      .read_data_out   (rdata),
      .read_valid_out  (rvalid),
      .cfg_regs_out    (regs),
      .config_err_out  (err),
      .write_count_out (wcnt)
   );

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic r);
      addr = a;
      data = d;
      wr   = w;
      rd   = r;
   endtask

   task automatic idle();
      drive(32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      idle();
      exp_regs = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset state
      #3;
      chk("rst_valid", rvalid, 0);
      chk("rst_data", rdata, 0);
      chk("rst_err", err, 0);
      chk("rst_wcnt", wcnt, 0);
      chk("rst_regs", regs, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Write then read reg2
      drive(32'h02000015, 32'hDEADBEEF, 1'b1, 1'b0);
      step();
      exp_regs[64 +: 32] = 32'hDEADBEEF;
      drive(32'h02000015, 32'h0, 1'b0, 1'b1);
      chk("wr_regs", regs, exp_regs);
      chk("wr_wcnt", wcnt, 1);
      step();
      idle();
      chk("rd_valid", rvalid, RB);
      chk("rd_data", rdata, RB ? 32'hDEADBEEF : 32'h0);
      step();
      chk("rd_pulse_end", rvalid, 0);
      chk("rd_data_zero", rdata, 0);

      // Decode misses
      drive(32'h02000016, 32'h11111111, 1'b1, 1'b0);
      step();
      drive(32'h02010015, 32'h22222222, 1'b1, 1'b0);
      step();
      idle();
      chk("miss_regs", regs, exp_regs);
      chk("miss_wcnt", wcnt, 1);
      chk("miss_err", err, 0);

      // Preload regs 0..3 with 1..4
      for (int i = 0; i < 4; i++) begin
         drive({8'(i), 24'h000015}, 32'(i + 1), 1'b1, 1'b0);
         step();
         exp_regs[i*32 +: 32] = 32'(i + 1);
      end
      idle();
      chk("pre_regs", regs, exp_regs);
      chk("pre_wcnt", wcnt, 5);

      // Streaming reads, then reset during a 5th
      drive(32'h00000015, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         drive({8'(i + 1), 24'h000015}, 32'h0, 1'b0, 1'b1);
         chk($sformatf("str_valid%0d", i), rvalid, RB);
         chk($sformatf("str_data%0d", i), rdata, RB ? 32'(i + 1) : 32'h0);
      end
      drive(32'h00000015, 32'h0, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", rvalid, 0);
      chk("arst_regs", regs, 0);
      chk("arst_wcnt", wcnt, 0);
      exp_regs = '0;
      step();
      chk("arst_hold_valid", rvalid, 0);
      chk("arst_hold_data", rdata, 0);

      // Write ignored while reset low, accepted on first edge after
      drive(32'h03000015, 32'hCAFEF00D, 1'b1, 1'b0);
      step();
      chk("rstwr_ignored", regs, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      idle();
      exp_regs[96 +: 32] = 32'hCAFEF00D;
      chk("rstwr_first", regs, exp_regs);
      chk("rstwr_wcnt", wcnt, 1);

      // Simultaneous strobes
      drive(32'h01000015, 32'h12345678, 1'b1, 1'b1);
      step();
      idle();
      exp_regs[32 +: 32] = 32'h12345678;
      chk("sim_regs", regs, exp_regs);
      chk("sim_valid", rvalid, 0);
      chk("sim_err", err, RB);
      chk("sim_wcnt", wcnt, 2);

      // Out-of-range read, error stays set
      do_reset();
      drive(32'h09000015, 32'h0, 1'b0, 1'b1);
      step();
      idle();
      chk("oor_valid", rvalid, 0);
      chk("oor_err", err, RB);
      repeat (10) step();
      chk("oor_err_sticky", err, RB);

      // Out-of-range write
      drive(32'h08000015, 32'h55555555, 1'b1, 1'b0);
      step();
      idle();
      chk("oorw_err", err, 1);
      chk("oorw_regs", regs, 0);
      chk("oorw_wcnt", wcnt, 0);

      // Read followed by write to same index returns old value
      drive(32'h05000015, 32'h0000AAAA, 1'b1, 1'b0);
      step();
      drive(32'h05000015, 32'h0, 1'b0, 1'b1);
      step();
      drive(32'h05000015, 32'h0000BBBB, 1'b1, 1'b0);
      chk("raw_valid", rvalid, RB);
      chk("raw_data", rdata, RB ? 32'h0000AAAA : 32'h0);
      step();
      idle();
      exp_regs[160 +: 32] = 32'h0000BBBB;
      chk("raw_regs", regs, exp_regs);
      chk("raw_wcnt", wcnt, 2);

      // Write count saturation
      do_reset();
      drive(32'h07000015, 32'h1, 1'b1, 1'b0);
      repeat (65534) @(posedge clk);
      #1;
      idle();
      chk("sat_fffe", wcnt, 16'hFFFE);
      drive(32'h06000015, 32'h2, 1'b1, 1'b0);
      repeat (3) step();
      idle();
      chk("sat_ffff", wcnt, 16'hFFFF);
      step();
      chk("sat_hold", wcnt, 16'hFFFF);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
